// File: rtl/prefetch_pkg.sv
// Types and helpers shared by the stride detector and the prefetch issuer.
package prefetch_pkg;

  localparam int PF_ADDR_BITS = 64;

  typedef enum logic {s_idle, s_issue} pfState_t;

  typedef logic [PF_ADDR_BITS-1:0] pfAddr_t;

  // A stride step left the address space if the carry disagrees with the stride sign.
  function automatic logic addrWrapped(input logic carry, input logic strideNeg);
    return strideNeg ? !carry : carry;
  endfunction

endpackage

// File: rtl/pf_credit_counter.sv
// Saturating outstanding-request counter; a simultaneous inc and dec holds the count.
module pf_credit_counter #(
  parameter int MAX = 8
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       full
);

  logic [$clog2(MAX+1)-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == ($clog2(MAX+1))'(MAX));

endmodule

// File: rtl/stride_prefetch_issuer.sv
// Turns each strided demand access into a burst of DEPTH block-aligned prefetches.
// Define PF_PAGE_CLAMP_EN to stop bursts at the trigger's page boundary.
module stride_prefetch_issuer
  import prefetch_pkg::*;
#(
  parameter int ADDR_BITS       = PF_ADDR_BITS,
  parameter int BLOCK_BITS      = 6,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int PAGE_BITS       = 12
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  en,
  input  logic                                  accessValid,
  input  logic [ADDR_BITS-1:0]                  accessAddr,
  input  logic [ADDR_BITS-1:0]                  stride,
  output logic                                  pfReqValid,
  output logic [ADDR_BITS-1:0]                  pfReqAddr,
  input  logic                                  pfReqReady,
  input  logic                                  pfRespValid,
  output logic                                  busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);

  localparam logic [ADDR_BITS-1:0] ALIGN_MASK =
    {{(ADDR_BITS-BLOCK_BITS){1'b1}}, {BLOCK_BITS{1'b0}}};

  if (DEPTH < 1 || DEPTH > 255 || PAGE_BITS <= BLOCK_BITS || PAGE_BITS >= ADDR_BITS) begin : gBadParams
    $error("stride_prefetch_issuer: DEPTH or PAGE_BITS out of range");
  end

  pfState_t              state_q, state_d;
  logic [ADDR_BITS-1:0]  nextAddr_q, nextAddr_d;
  logic [ADDR_BITS-1:0]  stride_q, stride_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pendValid_q, pendValid_d;
  logic [ADDR_BITS-1:0]  pendAddr_q, pendAddr_d;
  logic [ADDR_BITS-1:0]  pendStride_q, pendStride_d;

  logic                  trigger, hs, creditFull, load;
  logic [ADDR_BITS-1:0]  loadAddr, loadStride, loadFirst, stepAddr;
  logic                  loadCarry, stepCarry, loadCross, stepCross, loadOk, stepOk;

  assign trigger    = accessValid & en & (stride != '0);
  assign hs         = pfReqValid & pfReqReady;

  // A fresh trigger always wins over the older pending one.
  assign loadAddr   = trigger ? accessAddr : pendAddr_q;
  assign loadStride = trigger ? stride     : pendStride_q;
  assign {loadCarry, loadFirst} = {1'b0, loadAddr} + {1'b0, loadStride};
  assign {stepCarry, stepAddr}  = {1'b0, nextAddr_q} + {1'b0, stride_q};

`ifdef PF_PAGE_CLAMP_EN
  logic [ADDR_BITS-1:0] base_q;

  assign loadCross = loadFirst[ADDR_BITS-1:PAGE_BITS] != loadAddr[ADDR_BITS-1:PAGE_BITS];
  assign stepCross = stepAddr[ADDR_BITS-1:PAGE_BITS]  != base_q[ADDR_BITS-1:PAGE_BITS];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      base_q <= '0;
    end else if (load) begin
      base_q <= loadAddr;
    end
  end
`else
  assign loadCross = 1'b0;
  assign stepCross = 1'b0;
`endif

  assign loadOk = !addrWrapped(loadCarry, loadStride[ADDR_BITS-1]) && !loadCross;
  assign stepOk = !addrWrapped(stepCarry, stride_q[ADDR_BITS-1]) && !stepCross;

  pf_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) uCredit (
    .clk    (clk),
    .resetN (resetN),
    .inc    (hs),
    .dec    (pfRespValid),
    .count  (outstanding),
    .full   (creditFull)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= s_idle;
      nextAddr_q   <= '0;
      stride_q     <= '0;
      cnt_q        <= '0;
      pendValid_q  <= 1'b0;
      pendAddr_q   <= '0;
      pendStride_q <= '0;
    end else begin
      state_q      <= state_d;
      nextAddr_q   <= nextAddr_d;
      stride_q     <= stride_d;
      cnt_q        <= cnt_d;
      pendValid_q  <= pendValid_d;
      pendAddr_q   <= pendAddr_d;
      pendStride_q <= pendStride_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nextAddr_d   = nextAddr_q;
    stride_d     = stride_q;
    cnt_d        = cnt_q;
    pendValid_d  = pendValid_q;
    pendAddr_d   = pendAddr_q;
    pendStride_d = pendStride_q;
    load         = 1'b0;
    unique case (state_q)
      s_idle: begin
        if (trigger || pendValid_q) begin
          pendValid_d = 1'b0;
          load        = loadOk;
        end
      end
      s_issue: begin
        if (hs) begin
          nextAddr_d = stepAddr;
          cnt_d      = cnt_q + 8'd1;
          if ((cnt_q == 8'(DEPTH-1)) || !stepOk) begin
            state_d = s_idle;
            if (trigger) begin
              pendValid_d = 1'b0;
              load        = loadOk;
            end
          end else if (trigger || pendValid_q) begin
            // Abort the burst; whatever is pending starts after one idle cycle.
            state_d = s_idle;
            if (trigger) begin
              pendValid_d  = 1'b1;
              pendAddr_d   = accessAddr;
              pendStride_d = stride;
            end
          end
        end else if (trigger) begin
          pendValid_d  = 1'b1;
          pendAddr_d   = accessAddr;
          pendStride_d = stride;
        end
      end
      default: state_d = s_idle;
    endcase
    if (load) begin
      state_d    = s_issue;
      nextAddr_d = loadFirst;
      stride_d   = loadStride;
      cnt_d      = '0;
    end
  end

  // Valid only depends on state and credit, and credit cannot drop while valid is held.
  always_comb begin
    pfReqValid = 1'b0;
    pfReqAddr  = '0;
    busy       = pendValid_q;
    if (state_q == s_issue) begin
      pfReqValid = !creditFull;
      pfReqAddr  = nextAddr_q & ALIGN_MASK;
      busy       = 1'b1;
    end
  end

endmodule

// File: tb/tb_stride_prefetch_issuer.sv
// Scoreboard bench for stride_prefetch_issuer: expected request addresses are queued
// when a trigger is driven and popped as the DUT's handshakes happen.
module tb_stride_prefetch_issuer;

  localparam int AW = 64;

  logic          clk;
  logic          resetN;
  logic          en;
  logic          accessValid;
  logic [AW-1:0] accessAddr;
  logic [AW-1:0] stride;
  logic          pfReqValid;
  logic [AW-1:0] pfReqAddr;
  logic          pfReqReady;
  logic          pfRespValid;
  logic          busy;
  logic [3:0]    outstanding;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] expQ[$];
  logic          prevHeld = 1'b0;
  logic [AW-1:0] prevAddr = '0;

  stride_prefetch_issuer dut (
    .clk         (clk),
    .resetN      (resetN),
    .en          (en),
    .accessValid (accessValid),
    .accessAddr  (accessAddr),
    .stride      (stride),
    .pfReqValid  (pfReqValid),
    .pfReqAddr   (pfReqAddr),
    .pfReqReady  (pfReqReady),
    .pfRespValid (pfRespValid),
    .busy        (busy),
    .outstanding (outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [AW-1:0] observed, input logic [AW-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [AW-1:0] str);
    accessValid = 1'b1;
    accessAddr  = addr;
    stride      = str;
    tick(1);
    accessValid = 1'b0;
  endtask

  task automatic sendResp(input int n);
    pfRespValid = 1'b1;
    tick(n);
    pfRespValid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {63'd0, busy}, 64'd0);
    checkOutput({tag, " drained"}, 64'(expQ.size()), 64'd0);
  endtask

  // Inputs only change just after posedge, so a handshake seen here is taken at the next edge.
  always @(negedge clk) begin
    if (resetN) begin
      if (prevHeld) begin
        checkOutput("hold valid", {63'd0, pfReqValid}, 64'd1);
        checkOutput("hold addr", pfReqAddr, prevAddr);
      end
      if (pfReqValid && pfReqReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected req", 64'(expQ.size()), 64'd1);
        end else begin
          checkOutput("req addr", pfReqAddr, expQ.pop_front());
        end
      end
    end
    prevHeld = resetN && pfReqValid && !pfReqReady;
    prevAddr = pfReqAddr;
  end

  initial begin
    resetN      = 1'b0;
    en          = 1'b1;
    accessValid = 1'b0;
    accessAddr  = '0;
    stride      = '0;
    pfReqReady  = 1'b0;
    pfRespValid = 1'b0;
    tick(2);
    checkOutput("reset valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("reset addr", pfReqAddr, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset outst", 64'(outstanding), 64'd0);
    resetN = 1'b1;
    tick(1);

    pfReqReady = 1'b1;
    expQ.push_back(64'h1040); expQ.push_back(64'h1080);
    expQ.push_back(64'h10C0); expQ.push_back(64'h1100);
    applyStimulus(64'h1000, 64'h40);
    checkOutput("basic first valid", {63'd0, pfReqValid}, 64'd1);
    checkOutput("basic first addr", pfReqAddr, 64'h1040);
    tick(4);
    checkOutput("basic end valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("basic end busy", {63'd0, busy}, 64'd0);
    checkOutput("basic outst", 64'(outstanding), 64'd4);
    checkOutput("basic drained", 64'(expQ.size()), 64'd0);
    sendResp(4);
    checkOutput("basic resp outst", 64'(outstanding), 64'd0);

    expQ.push_back(64'h0FC0); expQ.push_back(64'h0F80);
    expQ.push_back(64'h0F40); expQ.push_back(64'h0F00);
    applyStimulus(64'h1000, 64'hFFFF_FFFF_FFFF_FFC0);
    waitIdle("neg idle");
    sendResp(4);

    for (int b = 0; b < 2; b++) begin
      for (int k = 1; k <= 4; k++) expQ.push_back(64'h1000 + 64'(k) * 64'h40);
      applyStimulus(64'h1000, 64'h40);
      waitIdle("fill idle");
    end
    checkOutput("credit full outst", 64'(outstanding), 64'd8);
    pfReqReady = 1'b0;
    expQ.push_back(64'h3040);
    applyStimulus(64'h3000, 64'h40);
    checkOutput("credit stall valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("credit stall busy", {63'd0, busy}, 64'd1);
    sendResp(1);
    checkOutput("credit resume valid", {63'd0, pfReqValid}, 64'd1);
    checkOutput("credit resume addr", pfReqAddr, 64'h3040);
    tick(3);
    checkOutput("credit held addr", pfReqAddr, 64'h3040);
    pfReqReady = 1'b1;
    tick(1);
    checkOutput("credit refull valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("credit refull outst", 64'(outstanding), 64'd8);
    expQ.push_back(64'h3080); expQ.push_back(64'h30C0); expQ.push_back(64'h3100);
    sendResp(20);
    waitIdle("credit idle");
    checkOutput("credit drain outst", 64'(outstanding), 64'd0);

    pfReqReady = 1'b0;
    expQ.push_back(64'h1040); expQ.push_back(64'h1080);
    for (int k = 1; k <= 4; k++) expQ.push_back(64'h2000 + 64'(k) * 64'h40);
    applyStimulus(64'h1000, 64'h40);
    pfReqReady = 1'b1;
    tick(1);
    pfReqReady = 1'b0;
    applyStimulus(64'h2000, 64'h40);
    checkOutput("preempt held addr", pfReqAddr, 64'h1080);
    pfReqReady = 1'b1;
    tick(1);
    checkOutput("preempt gap valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("preempt gap busy", {63'd0, busy}, 64'd1);
    tick(1);
    checkOutput("preempt new addr", pfReqAddr, 64'h2040);
    waitIdle("preempt idle");
    sendResp(8);

    expQ.push_back(64'hFFFF_FFFF_FFFF_FFC0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FF80, 64'h40);
    checkOutput("wrap addr", pfReqAddr, 64'hFFFF_FFFF_FFFF_FFC0);
    tick(1);
    checkOutput("wrap end busy", {63'd0, busy}, 64'd0);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFC0, 64'h40);
    checkOutput("wrap first busy", {63'd0, busy}, 64'd0);
    checkOutput("wrap first valid", {63'd0, pfReqValid}, 64'd0);

    expQ.push_back(64'h1FC0);
`ifndef PF_PAGE_CLAMP_EN
    expQ.push_back(64'h2000); expQ.push_back(64'h2040); expQ.push_back(64'h2080);
`endif
    applyStimulus(64'h1F80, 64'h40);
    waitIdle("page idle");
    sendResp(8);

    applyStimulus(64'h4000, 64'h0);
    checkOutput("stride0 busy", {63'd0, busy}, 64'd0);
    checkOutput("stride0 valid", {63'd0, pfReqValid}, 64'd0);
    en = 1'b0;
    applyStimulus(64'h4000, 64'h40);
    checkOutput("en low busy", {63'd0, busy}, 64'd0);
    en = 1'b1;

    expQ.push_back(64'h5040); expQ.push_back(64'h5080);
    applyStimulus(64'h5000, 64'h40);
    tick(2);
    checkOutput("pre-reset outst", 64'(outstanding), 64'd2);
    checkOutput("pre-reset addr", pfReqAddr, 64'h50C0);
    resetN = 1'b0;
    #1;
    checkOutput("mid reset valid", {63'd0, pfReqValid}, 64'd0);
    checkOutput("mid reset addr", pfReqAddr, 64'd0);
    checkOutput("mid reset busy", {63'd0, busy}, 64'd0);
    checkOutput("mid reset outst", 64'(outstanding), 64'd0);
    tick(1);
    resetN = 1'b1;
    sendResp(2);
    checkOutput("stale resp outst", 64'(outstanding), 64'd0);
    checkOutput("final drained", 64'(expQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stride_prefetch_issuer.md
# stride_prefetch_issuer

Consumes the stride produced by the stride-detection FSM and turns each demand access into a burst of block-aligned prefetch requests at `addr + k*stride`, k = 1..DEPTH. It sits between the stride detector and the memory-side prefetch port. It issues requests over a valid/ready handshake and tracks outstanding prefetches against a credit limit.

## Interface
- ADDR_BITS, 64, address width.
- BLOCK_BITS, 6, log2 cache-block size; low BLOCK_BITS of every issued address are zero.
- DEPTH, 4, prefetches per trigger (1..255).
- MAX_OUTSTANDING, 8, credit limit on accepted-but-uncompleted prefetches.
- PAGE_BITS, 12, log2 page size; used only when PF_PAGE_CLAMP_EN is defined.
- clk  in  1  clock.
- resetN  in  1  reset, asynchronous, active-low.
- en  in  1  trigger enable; when low, accessValid is ignored.
- accessValid  in  1  demand access this cycle.
- accessAddr  in  ADDR_BITS  demand address, block-aligned.
- stride  in  ADDR_BITS  two's-complement stride from detector; 0 = no stride.
- pfReqValid  out  1  prefetch request valid.
- pfReqAddr  out  ADDR_BITS  prefetch address.
- pfReqReady  in  1  memory side accepts request.
- pfRespValid  in  1  one prefetch completed (one-cycle pulse per completion).
- busy  out  1  burst in progress or pending trigger held.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

## Operation
- Trigger: accessValid & en & stride != 0. Ignored when stride == 0.
- The FSM has two states.
  - s_idle: on trigger, load nextAddr = accessAddr + stride, cnt = 0, and latched stride. Go to s_issue.
  - s_issue: pfReqValid = (outstanding < MAX_OUTSTANDING); pfReqAddr = nextAddr with low BLOCK_BITS masked to 0.
    - Handshake (valid & ready): nextAddr += stride; cnt++.
    - If cnt reaches DEPTH, or the burst terminates, go to s_idle.
- Handshake stability: once pfReqValid is high, pfReqValid and pfReqAddr hold until accepted. Credit cannot decrease while valid is held, so this is always satisfiable.
- Trigger during s_issue is latched into a one-deep pending register (address + stride); a newer trigger overwrites it.
  - On completion of the current handshake, the burst is aborted: remaining k are dropped.
  - Next cycle, the pending trigger is loaded as in s_idle.
  - A trigger in the same cycle as the final handshake is loaded directly, with no idle cycle.
- Wrap-around: addition is modulo 2^ADDR_BITS. If computing the next address overflows (stride > 0 and carry out) or underflows (stride < 0 and no carry), the burst terminates. No wrapped address is ever issued.
- Outstanding counter:
  - +1 on handshake, −1 on pfRespValid; unchanged when both occur.
  - pfRespValid at 0 is ignored (no underflow).
  - Never exceeds MAX_OUTSTANDING.
- busy = (state == s_issue) | pendingValid.
- Reset mid-burst clears the FSM, pending register and counter immediately. Completions for requests accepted before reset are ignored.

## Timing
- Reset values: pfReqValid 0, pfReqAddr 0, busy 0, outstanding 0. Internal nextAddr, cnt, stride and pending all 0.
- Trigger sampled at edge T; first pfReqValid is visible after edge T, in cycle T+1.
- Throughput: one request per cycle while pfReqReady is high and credit is available.
- Credit stall:
  - Valid drops in the cycle outstanding == MAX_OUTSTANDING.
  - Valid reasserts the cycle after a pfRespValid edge decrements the count.
- Issue-to-idle: after the DEPTH-th handshake at edge E, pfReqValid and busy are low after E, unless a pending trigger exists.
- The outstanding output is registered and reflects handshakes and completions from the previous edge.

## Configuration
- PF_PAGE_CLAMP_EN defined:
  - The burst terminates when the next address differs from the trigger address in bits above PAGE_BITS.
  - The crossing address is never issued.
- Undefined: only ADDR_BITS wrap-around terminates a burst; page crossings are issued.

## Structure
- Shared package prefetch_pkg: ADDR_BITS default, the state enum (s_idle, s_issue), and the address typedef shared with the stride detector.
- Sub-module pf_credit_counter:
  - Parameter MAX.
  - Inputs inc, dec.
  - Outputs count, full.
  - Saturating, simultaneous inc/dec = hold.

## Test plan
- Basic burst: stride 0x40, access 0x1000, ready held 1 → requests 0x1040, 0x1080, 0x10C0, 0x1100 in cycles T+1..T+4; busy low at T+5; outstanding 4.
- Negative stride: stride −0x40 (0xFFFF…FFC0), access 0x1000 → 0x0FC0, 0x0F80, 0x0F40, 0x0F00.
- Backpressure and credit: MAX_OUTSTANDING 2, ready 1, no responses.
  - Exactly 2 requests issue, then valid low.
  - One pfRespValid → third request 0x10C0 issues on the next cycle.
  - With ready 0, addr stays stable.
- Preemption: trigger 0x2000 while the second request of a 0x1000 burst is held.
  - 0x1080 completes.
  - Next requests come from the new base: 0x2040, etc.
- Wrap and page boundary:
  - Access 0xFFFF_FFFF_FFFF_FF80, stride 0x40 → only …FFC0 issued, then idle.
  - With PF_PAGE_CLAMP_EN: access 0x1F80, stride 0x40 → only 0x1FC0 issued.
- Reset mid-burst and stride 0: resetN low during s_issue → all outputs 0 immediately; trigger with stride 0 → no request, busy stays 0.
